// File: rtl/keypad_event_encoder.sv
// rtl/keypad_event_encoder.sv - keypad synchroniser, debouncer and press/release event FIFO
//
// Purpose: synchronises and debounces 12 raw keypad buttons and turns every
// debounced press or release into a {release, code} event. Events wait in a
// pending set, are arbitrated one per cycle into a first-word-fall-through
// FIFO, and are handed to the consumer on a valid/ready handshake.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   btn_raw      raw buttons, 1 = pressed (bit 10 star, bit 11 sharp)
//   key_code     head event key code (0..9 digits, 10 star, 11 sharp)
//   key_release  head event type (0 press, 1 release)
//   key_valid    FIFO non-empty, head event presented
//   key_ready    consumer takes the head event when key_valid is high
//   key_held     debounced level per key
//   fifo_count   number of buffered events
//   overflow     sticky flag: a pending event was merged and lost

module keypad_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [11:0]   btn_raw,
  output logic [3:0]    key_code,
  output logic          key_release,
  output logic          key_valid,
  input  logic          key_ready,
  output logic [11:0]   key_held,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [11:0] s1;
  logic [11:0] s2;
  logic [11:0] stable;
  logic [7:0]  cnt [12];
  logic [11:0] accept;
  logic [11:0] set_press;
  logic [11:0] set_rel;

  logic [11:0] pend_press;
  logic [11:0] pend_rel;
  logic [11:0] clr_press;
  logic [11:0] clr_rel;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        win_rel;
  logic [3:0]  win_code;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // A key's new level is accepted on the cycle its counter has already seen
  // DEBOUNCE_CYCLES-1 differing samples and the current sample still differs.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 12; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign set_press = accept & s2;
  assign set_rel   = accept & ~s2;
  assign key_held  = stable;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < 12; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      for (int i = 0; i < 12; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Presses outrank releases; within a class the lowest key index wins.
  // Loops run high to low so the last (lowest) hit is the one kept.
  always_comb begin
    win_code  = '0;
    win_rel   = 1'b0;
    clr_press = '0;
    clr_rel   = '0;
    for (int i = 11; i >= 0; i--) begin
      if (pend_rel[i]) begin
        win_code = 4'(i);
        win_rel  = 1'b1;
      end
    end
    for (int i = 11; i >= 0; i--) begin
      if (pend_press[i]) begin
        win_code = 4'(i);
        win_rel  = 1'b0;
      end
    end
    push = !fifo_full && ((|pend_press) || (|pend_rel));
    if (push) begin
      if (win_rel) clr_rel[win_code]   = 1'b1;
      else         clr_press[win_code] = 1'b1;
    end
  end

  // A new set always survives a same-cycle clear, so no event is dropped there;
  // only a set landing on a bit that stays pending loses an event.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_press <= '0;
      pend_rel   <= '0;
      overflow   <= 1'b0;
    end else begin
      pend_press <= (pend_press & ~clr_press) | set_press;
      pend_rel   <= (pend_rel & ~clr_rel) | set_rel;
      if (|((set_press & pend_press & ~clr_press) | (set_rel & pend_rel & ~clr_rel))) begin
        overflow <= 1'b1;
      end
    end
  end

  // Full blocks the push even when a pop frees a slot in the same cycle.
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign key_valid = (fifo_count != '0);
  assign pop       = key_valid & key_ready;
  assign {key_release, key_code} = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {win_rel, win_code};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_event_encoder.sv
// tb/tb_keypad_event_encoder.sv - self-checking bench for keypad_event_encoder

module tb_keypad_event_encoder;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [11:0]   btn_raw = '0;
  logic [3:0]    key_code;
  logic          key_release;
  logic          key_valid;
  logic          key_ready = 1'b0;
  logic [11:0]   key_held;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  keypad_event_encoder #(.DEBOUNCE_CYCLES(N), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .btn_raw(btn_raw),
    .key_code(key_code), .key_release(key_release), .key_valid(key_valid),
    .key_ready(key_ready), .key_held(key_held), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Reference model: synchroniser as a two-deep delay line, debouncing as
  // "the last N synchronised samples all disagree with the held level",
  // pending events as bit sets, FIFO as a queue.
  logic [11:0] sync_q[$] = '{12'h0, 12'h0};
  logic [11:0] s2_hist[$];
  logic [11:0] m_stable = '0;
  logic [11:0] m_pp = '0;
  logic [11:0] m_pr = '0;
  bit          m_ovf = 1'b0;
  logic [4:0]  m_q[$];

  task automatic model_reset();
    sync_q = '{12'h0, 12'h0};
    s2_hist.delete();
    m_stable = '0;
    m_pp = '0;
    m_pr = '0;
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic [11:0] s2v, acc, setp, setr, clrp, clrr;
    bit push, pop, all_diff;
    s2v = sync_q.pop_front();
    sync_q.push_back(btn_raw);
    s2_hist.push_back(s2v);
    if (s2_hist.size() > N) void'(s2_hist.pop_front());
    acc = '0;
    if (s2_hist.size() == N) begin
      for (int i = 0; i < 12; i++) begin
        all_diff = 1'b1;
        foreach (s2_hist[j]) if (s2_hist[j][i] == m_stable[i]) all_diff = 1'b0;
        acc[i] = all_diff;
      end
    end
    setp = acc & ~m_stable;
    setr = acc & m_stable;
    m_stable = m_stable ^ acc;
    pop  = (m_q.size() > 0) && key_ready;
    push = 1'b0;
    clrp = '0;
    clrr = '0;
    if (m_q.size() < DEPTH) begin
      for (int i = 0; i < 12 && !push; i++)
        if (m_pp[i]) begin push = 1'b1; clrp[i] = 1'b1; end
      for (int i = 0; i < 12 && !push; i++)
        if (m_pr[i]) begin push = 1'b1; clrr[i] = 1'b1; end
    end
    if (|((setp & m_pp & ~clrp) | (setr & m_pr & ~clrr))) m_ovf = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      for (int i = 0; i < 12; i++) begin
        if (clrp[i]) m_q.push_back({1'b0, 4'(i)});
        if (clrr[i]) m_q.push_back({1'b1, 4'(i)});
      end
    end
    m_pp = (m_pp & ~clrp) | setp;
    m_pr = (m_pr & ~clrr) | setr;
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) model_reset();
    else     model_step();
  end

  logic [4:0] got_q[$];
  int         got_t[$];

  task automatic compare_model();
    check_eq("key_held", key_held, m_stable);
    check_eq("key_valid", key_valid, (m_q.size() != 0));
    check_eq("fifo_count", fifo_count, m_q.size());
    check_eq("overflow", overflow, m_ovf);
    if (m_q.size() != 0) check_eq("head_event", {key_release, key_code}, m_q[0]);
  endtask

  // Inputs are final when cyc is entered, so a handshake seen now is the one
  // the next rising edge completes.
  task automatic cyc();
    if (key_valid && key_ready) begin
      got_q.push_back({key_release, key_code});
      got_t.push_back(cyc_n);
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc_n++;
    compare_model();
  endtask

  int  held_j;
  int  valid_j;
  bit  seen2;

  initial begin
    // Reset state
    repeat (3) cyc();
    check_eq("rst_key_valid", key_valid, 0);
    check_eq("rst_key_code", key_code, 0);
    check_eq("rst_key_release", key_release, 0);
    check_eq("rst_fifo_count", fifo_count, 0);
    RST = 1'b0;
    repeat (3) cyc();

    // Single press: latency counted with the capture edge as edge 1
    btn_raw = 12'h008;
    held_j = 0;
    valid_j = 0;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      if (held_j == 0 && key_held[3]) held_j = j;
      if (valid_j == 0 && key_valid) valid_j = j;
    end
    check_eq("lat_held", held_j, N + 2);
    check_eq("lat_valid", valid_j, N + 3);
    check_eq("press_code", {key_release, key_code}, 5'h03);
    btn_raw = '0;
    key_ready = 1'b1;
    got_q.delete();
    repeat (15) cyc();
    check_eq("single_n", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("single_press", got_q[0], 5'h03);
      check_eq("single_release", got_q[1], 5'h13);
    end

    // Bounce on bit 5, then a short pulse on bit 2
    got_q.delete();
    for (int j = 0; j < 10; j++) begin
      btn_raw[5] = ~btn_raw[5];
      cyc();
    end
    btn_raw[5] = 1'b1;
    repeat (15) cyc();
    check_eq("bounce_n", got_q.size(), 1);
    if (got_q.size() == 1) check_eq("bounce_ev", got_q[0], 5'h05);
    got_q.delete();
    btn_raw[2] = 1'b1;
    repeat (3) cyc();
    btn_raw[2] = 1'b0;
    seen2 = 1'b0;
    repeat (12) begin
      cyc();
      seen2 |= key_held[2];
    end
    check_eq("pulse_held", seen2, 0);
    check_eq("pulse_n", got_q.size(), 0);

    // Simultaneous presses of keys 1 and 7
    btn_raw = '0;
    repeat (15) cyc();
    got_q.delete();
    got_t.delete();
    btn_raw = 12'h082;
    repeat (15) cyc();
    check_eq("simul_n", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("simul_first", got_q[0], 5'h01);
      check_eq("simul_second", got_q[1], 5'h07);
      check_eq("simul_gap", got_t[1] - got_t[0], 1);
    end

    // Backpressure: six presses with the consumer stalled
    btn_raw = '0;
    repeat (15) cyc();
    got_q.delete();
    key_ready = 1'b0;
    btn_raw = 12'h555;
    repeat (15) cyc();
    check_eq("bp_count", fifo_count, DEPTH);
    check_eq("bp_overflow", overflow, 0);
    key_ready = 1'b1;
    repeat (12) cyc();
    check_eq("bp_n", got_q.size(), 6);
    if (got_q.size() == 6)
      for (int j = 0; j < 6; j++) check_eq("bp_order", got_q[j], 5'(2 * j));

    // Overflow: FIFO full of releases, key 11 pressed and released twice
    key_ready = 1'b0;
    btn_raw = '0;
    repeat (12) cyc();
    for (int j = 0; j < 4; j++) begin
      btn_raw[11] = ~btn_raw[11];
      repeat (8) cyc();
    end
    check_eq("ovf_set", overflow, 1);
    key_ready = 1'b1;
    repeat (20) cyc();
    check_eq("ovf_sticky", overflow, 1);
    check_eq("ovf_drained", fifo_count, 0);
    RST = 1'b1;
    cyc();
    check_eq("ovf_cleared", overflow, 0);
    RST = 1'b0;
    repeat (2) cyc();

    // Random stimulus against the model
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(7) == 0) btn_raw[$urandom_range(11)] ^= 1'b1;
      if ($urandom_range(40) == 0) key_ready = 1'b0;
      else if ($urandom_range(5) == 0) key_ready = 1'b1;
      cyc();
    end

    // Asynchronous reset with three queued events, buttons still held after
    key_ready = 1'b1;
    btn_raw = '0;
    repeat (25) cyc();
    key_ready = 1'b0;
    btn_raw = 12'h007;
    repeat (15) cyc();
    check_eq("ar_queued", fifo_count, 3);
    #2 RST = 1'b1;
    #1;
    check_eq("ar_valid", key_valid, 0);
    check_eq("ar_count", fifo_count, 0);
    check_eq("ar_held", key_held, 0);
    @(negedge CLK);
    RST = 1'b0;
    got_q.delete();
    key_ready = 1'b1;
    repeat (15) cyc();
    check_eq("ar_repress_n", got_q.size(), 3);
    if (got_q.size() == 3)
      for (int j = 0; j < 3; j++) check_eq("ar_repress", got_q[j], 5'(j));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
